// File: rtl/core_pkg.sv
// Shared definitions for the execute stage: datapath defaults,
// ALU operation codes and forwarding selects.
package core_pkg;

    localparam int WIDTH_D   = 32;
    localparam int REGADDR_D = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/or/slt with zero, signed-overflow
// and illegal-code flags.
module alu_core
    import core_pkg::*;
#(
    parameter int WIDTH = WIDTH_D
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       CODE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVF,
    output logic             ILLEGAL
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = A + B;
    assign w_diff = A - B;
    assign w_lt   = $signed(A) < $signed(B);

    always_comb begin
        RESULT  = '0;
        OVF     = 1'b0;
        ILLEGAL = 1'b0;
        case (CODE)
            ALU_ADD: begin
                RESULT = w_sum;
                OVF    = (A[WIDTH-1] == B[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                RESULT = w_diff;
                OVF    = (A[WIDTH-1] != B[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_AND: RESULT = A & B;
            ALU_OR:  RESULT = A | B;
            ALU_SLT: RESULT = {{(WIDTH-1){1'b0}}, w_lt};
            default: ILLEGAL = 1'b1;
        endcase
    end

    assign ZERO = (RESULT == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline
// register with flush/stall control.
module ex_stage
    import core_pkg::*;
#(
    parameter int WIDTH   = WIDTH_D,
    parameter int REGADDR = REGADDR_D
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   SRCA_E,
    input  logic [WIDTH-1:0]   RD2_E,
    input  logic [WIDTH-1:0]   SIGNIMM_E,
    input  logic [2:0]         ALUCONTROL_E,
    input  logic               ALUSRC_E,
    input  logic               REGDST_E,
    input  logic [REGADDR-1:0] RT_E,
    input  logic [REGADDR-1:0] RD_E,
    input  logic               REGWRITE_E,
    input  logic               MEMTOREG_E,
    input  logic               MEMWRITE_E,
    input  logic               VALID_E,
    input  logic [1:0]         FORWARDA_E,
    input  logic [1:0]         FORWARDB_E,
    input  logic [WIDTH-1:0]   RESULT_W,
    input  logic               STALL_M,
    input  logic               FLUSH_M,
    output logic [WIDTH-1:0]   ALUOUT_M,
    output logic [WIDTH-1:0]   WRITEDATA_M,
    output logic [REGADDR-1:0] WRITEREG_M,
    output logic               REGWRITE_M,
    output logic               MEMTOREG_M,
    output logic               MEMWRITE_M,
    output logic               ZERO_M,
    output logic               OVF_M,
    output logic               ILLEGAL_M,
    output logic               VALID_M
);

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_fb;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_res;
    logic               w_zero;
    logic               w_ovf;
    logic               w_ill;
    logic [REGADDR-1:0] w_wreg;

    // Select 10 reads the registered ALUOUT_M, so a held value is
    // naturally reused while the register is stalled.
    always_comb begin
        case (FORWARDA_E)
            FWD_WB:  w_a = RESULT_W;
            FWD_MEM: w_a = ALUOUT_M;
            default: w_a = SRCA_E;
        endcase
        case (FORWARDB_E)
            FWD_WB:  w_fb = RESULT_W;
            FWD_MEM: w_fb = ALUOUT_M;
            default: w_fb = RD2_E;
        endcase
    end

    assign w_b    = ALUSRC_E ? SIGNIMM_E : w_fb;
    assign w_wreg = REGDST_E ? RD_E : RT_E;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .A       (w_a),
        .B       (w_b),
        .CODE    (ALUCONTROL_E),
        .RESULT  (w_res),
        .ZERO    (w_zero),
        .OVF     (w_ovf),
        .ILLEGAL (w_ill)
    );

    always_ff @(posedge CLK) begin
        if (RST || FLUSH_M) begin
            ALUOUT_M    <= '0;
            WRITEDATA_M <= '0;
            WRITEREG_M  <= '0;
            REGWRITE_M  <= 1'b0;
            MEMTOREG_M  <= 1'b0;
            MEMWRITE_M  <= 1'b0;
            ZERO_M      <= 1'b0;
            OVF_M       <= 1'b0;
            ILLEGAL_M   <= 1'b0;
            VALID_M     <= 1'b0;
        end else if (!STALL_M) begin
            ALUOUT_M    <= w_res;
            WRITEDATA_M <= w_fb;
            WRITEREG_M  <= w_wreg;
            REGWRITE_M  <= REGWRITE_E & VALID_E;
            MEMTOREG_M  <= MEMTOREG_E;
            MEMWRITE_M  <= MEMWRITE_E & VALID_E;
            ZERO_M      <= w_zero;
            OVF_M       <= w_ovf;
            ILLEGAL_M   <= w_ill & VALID_E;
            VALID_M     <= VALID_E;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: an independent reference model
// predicts each EX/MEM register image one edge ahead.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        z;
        logic        o;
        logic        ill;
        logic        v;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] SRCA_E, RD2_E, SIGNIMM_E, RESULT_W;
    logic [2:0]  ALUCONTROL_E;
    logic        ALUSRC_E, REGDST_E;
    logic [4:0]  RT_E, RD_E;
    logic        REGWRITE_E, MEMTOREG_E, MEMWRITE_E, VALID_E;
    logic [1:0]  FORWARDA_E, FORWARDB_E;
    logic        STALL_M, FLUSH_M;
    logic [31:0] ALUOUT_M, WRITEDATA_M;
    logic [4:0]  WRITEREG_M;
    logic        REGWRITE_M, MEMTOREG_M, MEMWRITE_M;
    logic        ZERO_M, OVF_M, ILLEGAL_M, VALID_M;

    int   n_run  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t m_prev = '0;

    always #5 CLK = ~CLK;

    ex_stage dut (
        .CLK(CLK), .RST(RST),
        .SRCA_E(SRCA_E), .RD2_E(RD2_E), .SIGNIMM_E(SIGNIMM_E),
        .ALUCONTROL_E(ALUCONTROL_E), .ALUSRC_E(ALUSRC_E),
        .REGDST_E(REGDST_E), .RT_E(RT_E), .RD_E(RD_E),
        .REGWRITE_E(REGWRITE_E), .MEMTOREG_E(MEMTOREG_E),
        .MEMWRITE_E(MEMWRITE_E), .VALID_E(VALID_E),
        .FORWARDA_E(FORWARDA_E), .FORWARDB_E(FORWARDB_E),
        .RESULT_W(RESULT_W), .STALL_M(STALL_M), .FLUSH_M(FLUSH_M),
        .ALUOUT_M(ALUOUT_M), .WRITEDATA_M(WRITEDATA_M),
        .WRITEREG_M(WRITEREG_M), .REGWRITE_M(REGWRITE_M),
        .MEMTOREG_M(MEMTOREG_M), .MEMWRITE_M(MEMWRITE_M),
        .ZERO_M(ZERO_M), .OVF_M(OVF_M), .ILLEGAL_M(ILLEGAL_M),
        .VALID_M(VALID_M)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] reg_v);
        if (sel == 2'd1) return RESULT_W;
        if (sel == 2'd2) return m_prev.alu;
        return reg_v;
    endfunction

    function automatic exp_t model();
        exp_t   e;
        logic [31:0] a, fb, b;
        longint sa, sb, s;
        e = '0;
        if (RST || FLUSH_M) return e;
        if (STALL_M) return m_prev;
        a  = pick(FORWARDA_E, SRCA_E);
        fb = pick(FORWARDB_E, RD2_E);
        b  = ALUSRC_E ? SIGNIMM_E : fb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ALUCONTROL_E)
            3'b010: begin
                s = sa + sb; e.alu = a + b;
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                s = sa - sb; e.alu = a - b;
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b000: e.alu = a & b;
            3'b001: e.alu = a | b;
            3'b111: e.alu = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = VALID_E;
        endcase
        e.z    = (e.alu == 32'd0);
        e.wd   = fb;
        e.wreg = REGDST_E ? RD_E : RT_E;
        e.rw   = REGWRITE_E & VALID_E;
        e.m2r  = MEMTOREG_E;
        e.mw   = MEMWRITE_E & VALID_E;
        e.v    = VALID_E;
        return e;
    endfunction

    task automatic tick(input string tag);
        exp_t e;
        e = model();
        sb_q.push_back(e);
        m_prev = e;
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk(tag, {ALUOUT_M, WRITEDATA_M, WRITEREG_M, REGWRITE_M,
                  MEMTOREG_M, MEMWRITE_M, ZERO_M, OVF_M,
                  ILLEGAL_M, VALID_M}, e);
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] code);
        SRCA_E = a; RD2_E = b; ALUCONTROL_E = code;
        SIGNIMM_E = 32'h0; ALUSRC_E = 0; REGDST_E = 1;
        RT_E = 5'd3; RD_E = 5'd9;
        REGWRITE_E = 1; MEMTOREG_E = 0; MEMWRITE_E = 0; VALID_E = 1;
        FORWARDA_E = 0; FORWARDB_E = 0; RESULT_W = 32'h0;
        STALL_M = 0; FLUSH_M = 0; RST = 0;
    endtask

    task automatic rand_in();
        SRCA_E = $urandom; RD2_E = $urandom; SIGNIMM_E = $urandom;
        RESULT_W = $urandom; ALUCONTROL_E = 3'($urandom);
        ALUSRC_E = 1'($urandom); REGDST_E = 1'($urandom);
        RT_E = 5'($urandom); RD_E = 5'($urandom);
        REGWRITE_E = 1'($urandom); MEMTOREG_E = 1'($urandom);
        MEMWRITE_E = 1'($urandom); VALID_E = 1'($urandom);
        FORWARDA_E = 2'($urandom); FORWARDB_E = 2'($urandom);
        STALL_M = ($urandom_range(0, 3) == 0);
        FLUSH_M = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        logic [31:0] codes [5];
        logic [31:0] alus  [5];
        codes = '{32'd2, 32'd6, 32'd0, 32'd1, 32'd7};
        alus  = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0};

        rand_in(); RST = 1;
        tick("rst0");
        rand_in(); RST = 1;
        tick("rst1");
        chk("rst_valid", VALID_M, 0);

        for (int i = 0; i < 5; i++) begin
            set_op(32'd7, 32'd5, codes[i][2:0]);
            tick("alu_code");
            chk("alu_val", ALUOUT_M, alus[i]);
            chk("alu_zero", ZERO_M, (i == 4));
        end

        set_op(32'd3, 32'd4, 3'b010);
        tick("fwd_base");
        set_op(32'd999, 32'd1, 3'b010); FORWARDA_E = 2'b10;
        tick("fwd_mem");
        chk("fwd_mem_val", ALUOUT_M, 32'd8);
        set_op(32'd999, 32'd1, 3'b010);
        FORWARDA_E = 2'b01; RESULT_W = 32'd100;
        tick("fwd_wb");
        chk("fwd_wb_val", ALUOUT_M, 32'd101);
        set_op(32'd6, 32'd1, 3'b010);
        FORWARDA_E = 2'b11; RESULT_W = 32'd100;
        tick("fwd_11");
        chk("fwd_11_val", ALUOUT_M, 32'd7);

        set_op(32'h7FFF_FFFF, 32'd1, 3'b010);
        tick("ovf");
        chk("ovf_val", {ALUOUT_M, OVF_M}, {32'h8000_0000, 1'b1});
        set_op(32'h8000_0000, 32'd1, 3'b110);
        tick("ovf_sub");
        chk("ovf_sub_flag", OVF_M, 1);
        set_op(32'd7, 32'd5, 3'b100);
        tick("illegal");
        chk("illegal_val", {ALUOUT_M, ILLEGAL_M}, {32'd0, 1'b1});
        set_op(32'd7, 32'd5, 3'b101); VALID_E = 0; MEMWRITE_E = 1;
        tick("inval_mask");
        chk("inval_flags", {REGWRITE_M, MEMWRITE_M, ILLEGAL_M, VALID_M},
            4'b0000);

        set_op(32'd40, 32'd2, 3'b010);
        tick("stall_load");
        for (int i = 0; i < 3; i++) begin
            set_op(32'd1, 32'd1, 3'b110);
            STALL_M = 1; FORWARDA_E = 2'b10;
            tick("stall_hold");
            chk("stall_val", ALUOUT_M, 32'd42);
        end
        set_op(32'd1, 32'd1, 3'b010); FORWARDA_E = 2'b10;
        tick("stall_fwd");
        chk("stall_fwd_val", ALUOUT_M, 32'd43);
        set_op(32'd1, 32'd1, 3'b010); STALL_M = 1; FLUSH_M = 1;
        tick("flush");
        chk("flush_val", {VALID_M, REGWRITE_M, ALUOUT_M}, 34'd0);

        set_op(32'd20, 32'h55, 3'b010);
        ALUSRC_E = 1; SIGNIMM_E = 32'hFFFF_FFFC;
        FORWARDB_E = 2'b01; RESULT_W = 32'hAA; MEMWRITE_E = 1;
        tick("store");
        chk("store_val", {WRITEDATA_M, ALUOUT_M, MEMWRITE_M},
            {32'hAA, 32'd16, 1'b1});

        set_op(32'd5, 32'd5, 3'b010); STALL_M = 1; RST = 1;
        tick("rst_stall");
        chk("rst_stall_val", {ALUOUT_M, VALID_M}, 33'd0);

        for (int i = 0; i < 60; i++) begin
            rand_in(); RST = ($urandom_range(0, 29) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
